// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS sequencer: state codes, opcode and
// funct constants, ALU operand/operation selects and the control word layout.
package mips_multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_JR        = 4'd13,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // Datapath control word, decoded from the current state.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       trap;
    } ctrl_t;

    // States that hold a memory request open until MemReady.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_wait_timer.sv
// Watchdog for a single memory access: counts cycles spent waiting on
// MemReady and flags the cycle in which the limit is reached without it.
module mips_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    // The increment that lands on MEM_TIMEOUT is the one that trips, so the
    // compare is against one less than the limit while still enabled.
    localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] cnt;

    // Wait counter: clear has priority so a state change always restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // en is already gated by MemReady, so a late MemReady beats the limit.
    assign timeout = en && (cnt == LIMIT);

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle sequencer for the MIPS-32 datapath. Steps each instruction
// through fetch/decode/execute/memory/writeback, holds memory requests until
// MemReady, and traps on illegal opcodes or a stalled memory access.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Trap,
    output logic [3:0] State
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   wait_en;
    logic   wait_clr;
    logic   timeout;

    // The datapath ANDs PCWriteCond with Zero itself; the flag is not needed here.
    logic unused_zero;
    assign unused_zero = Zero;

    assign wait_en  = is_mem_state(state) && !MemReady;
    assign wait_clr = (state_nxt != state);

    mips_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_wait_timer (
        .clk     (Clk),
        .rst_n   (reset),
        .clr     (wait_clr),
        .en      (wait_en),
        .timeout (timeout)
    );

    // Next-state selection; Opcode/Funct are only looked at in DECODE and MEM_ADDR.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      state_nxt = S_FETCH;
            S_FETCH: begin
                if (MemReady)     state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_TRAP;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_nxt = (Funct == FN_JR) ? S_JR : S_R_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_I_EXEC;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_nxt = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (MemReady)     state_nxt = S_MEM_WB;
                else if (timeout) state_nxt = S_TRAP;
            end
            S_MEM_WRITE: begin
                if (MemReady)     state_nxt = S_FETCH;
                else if (timeout) state_nxt = S_TRAP;
            end
            S_MEM_WB:    state_nxt = S_FETCH;
            S_R_EXEC:    state_nxt = S_R_WB;
            S_R_WB:      state_nxt = S_FETCH;
            S_I_EXEC:    state_nxt = S_I_WB;
            S_I_WB:      state_nxt = S_FETCH;
            S_BRANCH:    state_nxt = S_FETCH;
            S_JUMP:      state_nxt = S_FETCH;
            S_JR:        state_nxt = S_FETCH;
            S_TRAP:      state_nxt = S_TRAP;
            default:     state_nxt = S_TRAP;
        endcase
    end

    // State register; reset lands in IDLE so every enable drops at once.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Control decode: everything defaults low, each state raises only its own enables.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // Instruction and PC+4 only commit in the cycle memory delivers.
                ctrl.ir_write  = MemReady;
                ctrl.pc_write  = MemReady;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_I_EXEC, S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            S_JR: begin
                ctrl.pc_source = PCSRC_REG;
                ctrl.pc_write  = 1'b1;
            end
            S_TRAP: begin
                ctrl.trap = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegDst      = ctrl.reg_dst;
    assign MemToReg    = ctrl.mem_to_reg;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign Trap        = ctrl.trap;
    assign State       = state;

endmodule
